// File: rtl/instr_sequencer_if.sv
// Sequencer-facing bundle: instruction-memory handshake (Run/DIN/Done) plus
// the datapath control strobes driven by the sequencer.
interface instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Run;
  logic [8:0]       DIN;
  logic [8:0]       IR;
  logic [1:0]       Tstep;
  logic             IRin;
  logic [7:0]       Rin;
  logic [7:0]       Rout;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic             AddSub;
  logic             DINout;
  logic [3:0]       BusSel;
  logic             Done;
  logic             Busy;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output Run, DIN,
    input  IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout,
           BusSel, Done, Busy, Illegal, InstrCount
  );

  modport slave (
    input  Run, DIN,
    output IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout,
           BusSel, Done, Busy, Illegal, InstrCount
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle Tstep sequencer for the 9-bit bus processor: IR, opcode decode,
// datapath enables, bus-source select and a retired-instruction counter.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input logic               Clock,
  input logic               Reset,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

  localparam logic [3:0] SEL_G    = 4'd8;
  localparam logic [3:0] SEL_DIN  = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd15;

  tstep_t           state, state_nxt;
  logic [8:0]       ir;
  logic [CNT_W-1:0] cnt;

  logic [2:0] iii, xxx, yyy;
  logic       irin, ain, gin, gout, addsub, dinout, done, busy, illegal;
  logic [7:0] rin, rout;
  logic [3:0] bussel;

  assign iii = ir[8:6];
  assign xxx = ir[5:3];
  assign yyy = ir[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && bus.Run)
        ir <= bus.DIN;
      if (done)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      T0: state_nxt = bus.Run ? T1 : T0;
      T1: state_nxt = (iii == 3'b010 || iii == 3'b011) ? T2 : T0;
      T2: state_nxt = T3;
      T3: state_nxt = T0;
    endcase
  end

  // Reset overrides every strobe so an aborted instruction never shows Done.
  always_comb begin
    irin    = 1'b0;
    rin     = '0;
    rout    = '0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    addsub  = 1'b0;
    dinout  = 1'b0;
    bussel  = SEL_NONE;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = 1'b0;
    if (!Reset) begin
      busy = (state != T0);
      unique case (state)
        T0: irin = bus.Run;
        T1: begin
          unique case (iii)
            3'b000: begin
              rout   = 8'b1 << yyy;
              rin    = 8'b1 << xxx;
              bussel = {1'b0, yyy};
              done   = 1'b1;
            end
            3'b001: begin
              dinout = 1'b1;
              rin    = 8'b1 << xxx;
              bussel = SEL_DIN;
              done   = 1'b1;
            end
            3'b010, 3'b011: begin
              rout   = 8'b1 << xxx;
              ain    = 1'b1;
              bussel = {1'b0, xxx};
            end
            default: begin
              done    = 1'b1;
              illegal = 1'b1;
            end
          endcase
        end
        T2: begin
          rout   = 8'b1 << yyy;
          gin    = 1'b1;
          addsub = (iii == 3'b011);
          bussel = {1'b0, yyy};
        end
        T3: begin
          gout   = 1'b1;
          rin    = 8'b1 << xxx;
          bussel = SEL_G;
          done   = 1'b1;
        end
      endcase
    end
  end

  assign bus.IR         = ir;
  assign bus.Tstep      = state;
  assign bus.IRin       = irin;
  assign bus.Rin        = rin;
  assign bus.Rout       = rout;
  assign bus.Ain        = ain;
  assign bus.Gin        = gin;
  assign bus.Gout       = gout;
  assign bus.AddSub     = addsub;
  assign bus.DINout     = dinout;
  assign bus.BusSel     = bussel;
  assign bus.Done       = done;
  assign bus.Busy       = busy;
  assign bus.Illegal    = illegal;
  assign bus.InstrCount = cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-cycle outputs, a negedge
// monitor pops and compares them against the sequencer.
module tb_instr_sequencer;

  localparam int CW = 4;

  localparam logic [8:0] IRIN = 9'h100;
  localparam logic [8:0] BUSY = 9'h080;
  localparam logic [8:0] AIN  = 9'h040;
  localparam logic [8:0] GIN  = 9'h020;
  localparam logic [8:0] GOUT = 9'h010;
  localparam logic [8:0] ASUB = 9'h008;
  localparam logic [8:0] DOUT = 9'h004;
  localparam logic [8:0] DONE = 9'h002;
  localparam logic [8:0] ILL  = 9'h001;
  localparam logic [8:0] NOFL = 9'h000;

  typedef struct {
    string       nm;
    logic [43:0] v;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;

  instr_sequencer_if #(.CNT_W(CW)) bus ();

  instr_sequencer #(.CNT_W(CW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [CW-1:0] ecnt;

  wire [43:0] act = {bus.Tstep, bus.IR, bus.Rin, bus.Rout,
                     {bus.IRin, bus.Busy, bus.Ain, bus.Gin, bus.Gout,
                      bus.AddSub, bus.DINout, bus.Done, bus.Illegal},
                     bus.BusSel, bus.InstrCount};

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got ts=%h ir=%h rin=%h rout=%h fl=%h sel=%h cnt=%h, want ts=%h ir=%h rin=%h rout=%h fl=%h sel=%h cnt=%h",
                 e.nm, act[43:42], act[41:33], act[32:25], act[24:17], act[16:8], act[7:4], act[3:0],
                 e.v[43:42], e.v[41:33], e.v[32:25], e.v[24:17], e.v[16:8], e.v[7:4], e.v[3:0]);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic run, input logic [8:0] din,
                      input logic [1:0] ts, input logic [8:0] ir, input logic [7:0] rin,
                      input logic [7:0] rout, input logic [8:0] fl, input logic [3:0] sel);
    exp_t e;
    Reset   = rst;
    bus.Run = run;
    bus.DIN = din;
    e.nm = nm;
    e.v  = {ts, ir, rin, rout, fl, sel, ecnt};
    q.push_back(e);
    if (rst)        ecnt = '0;
    else if (fl[1]) ecnt = ecnt + 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [8:0] prev;
    Reset   = 1'b1;
    bus.Run = 1'b0;
    bus.DIN = '0;
    ecnt    = '0;
    repeat (2) @(posedge Clock);
    #1;

    step("reset_run_masked", 1, 1, 9'h058, 2'd0, 9'h000, 8'h00, 8'h00, NOFL, 4'hF);
    for (int i = 0; i < 5; i++)
      step("idle", 0, 0, 9'h1FF, 2'd0, 9'h000, 8'h00, 8'h00, NOFL, 4'hF);

    // mvi R3, #5
    step("mvi_t0", 0, 1, 9'h058, 2'd0, 9'h000, 8'h00, 8'h00, IRIN, 4'hF);
    step("mvi_t1", 0, 0, 9'h005, 2'd1, 9'h058, 8'h08, 8'h00, BUSY|DOUT|DONE, 4'd9);

    // sub R1,R2 with DIN junk after fetch
    step("sub_t0", 0, 1, 9'h0CA, 2'd0, 9'h058, 8'h00, 8'h00, IRIN, 4'hF);
    step("sub_t1", 0, 0, 9'h1FF, 2'd1, 9'h0CA, 8'h00, 8'h02, BUSY|AIN, 4'd1);
    step("sub_t2", 0, 1, 9'h000, 2'd2, 9'h0CA, 8'h00, 8'h04, BUSY|GIN|ASUB, 4'd2);
    step("sub_t3", 0, 1, 9'h1C0, 2'd3, 9'h0CA, 8'h02, 8'h00, BUSY|GOUT|DONE, 4'd8);
    step("idle_after_sub", 0, 0, 9'h000, 2'd0, 9'h0CA, 8'h00, 8'h00, NOFL, 4'hF);

    // mv R0,R7 then add R4,R4 with Run held high
    step("b2b_mv_t0", 0, 1, 9'h007, 2'd0, 9'h0CA, 8'h00, 8'h00, IRIN, 4'hF);
    step("b2b_mv_t1", 0, 1, 9'h1C0, 2'd1, 9'h007, 8'h01, 8'h80, BUSY|DONE, 4'd7);
    step("b2b_add_t0", 0, 1, 9'h0A4, 2'd0, 9'h007, 8'h00, 8'h00, IRIN, 4'hF);
    step("b2b_add_t1", 0, 1, 9'h1C0, 2'd1, 9'h0A4, 8'h00, 8'h10, BUSY|AIN, 4'd4);
    step("b2b_add_t2", 0, 1, 9'h1C0, 2'd2, 9'h0A4, 8'h00, 8'h10, BUSY|GIN, 4'd4);
    step("b2b_add_t3", 0, 0, 9'h1C0, 2'd3, 9'h0A4, 8'h10, 8'h00, BUSY|GOUT|DONE, 4'd8);

    // unsupported opcode
    step("ill_t0", 0, 1, 9'h1C0, 2'd0, 9'h0A4, 8'h00, 8'h00, IRIN, 4'hF);
    step("ill_t1", 0, 0, 9'h000, 2'd1, 9'h1C0, 8'h00, 8'h00, BUSY|DONE|ILL, 4'hF);
    step("ill_idle", 0, 0, 9'h000, 2'd0, 9'h1C0, 8'h00, 8'h00, NOFL, 4'hF);

    // reset in T2 of add aborts it
    step("abort_t0", 0, 1, 9'h0A4, 2'd0, 9'h1C0, 8'h00, 8'h00, IRIN, 4'hF);
    step("abort_t1", 0, 0, 9'h000, 2'd1, 9'h0A4, 8'h00, 8'h10, BUSY|AIN, 4'd4);
    step("abort_t2_rst", 1, 0, 9'h000, 2'd2, 9'h0A4, 8'h00, 8'h00, NOFL, 4'hF);
    step("abort_after", 0, 0, 9'h000, 2'd0, 9'h000, 8'h00, 8'h00, NOFL, 4'hF);

    // 16 back-to-back mv instructions wrap the 4-bit counter; upper half uses XXX==YYY
    prev = 9'h000;
    for (int unsigned i = 0; i < 16; i++) begin
      logic [2:0] x, y;
      logic [8:0] w;
      x = i[2:0];
      y = (i < 8) ? ~x : x;
      w = {3'b000, x, y};
      step("wrap_mv_t0", 0, 1, w, 2'd0, prev, 8'h00, 8'h00, IRIN, 4'hF);
      step("wrap_mv_t1", 0, 1, 9'h1FF, 2'd1, w, 8'b1 << x, 8'b1 << y, BUSY|DONE, {1'b0, y});
      prev = w;
    end
    step("wrap_idle", 0, 0, 9'h000, 2'd0, prev, 8'h00, 8'h00, NOFL, 4'hF);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge Clock);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the 9-bit bus processor: owns the instruction register (IR), the Tstep state machine and the decode of III/XXX/YYY.
- Drives all datapath enables (register file R0..R7, A, G, ALU AddSub, DIN bus driver) and the encoded bus-source select.
- Sits between instruction memory (DIN, Run) and the datapath. The Run/Done handshake is the only interface to the outside.
- Counts retired instructions for debug.

Parameters:
- CNT_W, 16, width of retired-instruction counter InstrCount

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  start request; sampled only in state T0
- DIN  in  9  instruction word in T0; immediate data in T1 of mvi
- IR  out  9  current instruction register
- Tstep  out  2  current state: 00=T0, 01=T1, 10=T2, 11=T3
- IRin  out  1  IR load strobe
- Rin  out  8  one-hot write enable for R0..R7
- Rout  out  8  one-hot bus drive for R0..R7
- Ain  out  1  load A
- Gin  out  1  load G
- Gout  out  1  G drives bus
- AddSub  out  1  1 = subtract, 0 = add; valid in the cycle Gin=1
- DINout  out  1  DIN drives bus
- BusSel  out  4  encoded bus source: 0-7 = Rn, 8 = G, 9 = DIN, 15 = none
- Done  out  1  one-cycle pulse in the final step of each instruction
- Busy  out  1  1 whenever Tstep != T0
- Illegal  out  1  one-cycle pulse with Done for an unsupported opcode
- InstrCount  out  CNT_W  number of Done pulses since reset

Behaviour:
- IR fields: III=IR[8:6] opcode, XXX=IR[5:3] destination, YYY=IR[2:0] source.
- Registered state: Tstep (2 b), IR (9 b), InstrCount. All other outputs are combinational from Tstep, IR and Run.
- Reset (sync): on the next edge Tstep=T0, IR=0, InstrCount=0.
  - While Reset=1, all combinational outputs are forced to 0, except BusSel=15.
  - Reset mid-instruction aborts the instruction: no Done, no count increment.
- Defaults in every state: all enables 0, BusSel=15, Done=0, Illegal=0.
- T0 (idle/fetch):
  - IRin=Run.
  - If Run=1: IR<=DIN and next state is T1. Otherwise stay in T0.
  - Busy=0.
- T1, by opcode:
  - 000 mv: Rout[YYY]=1, Rin[XXX]=1, BusSel=YYY, Done=1, next T0.
  - 001 mvi: DINout=1, Rin[XXX]=1, BusSel=9, Done=1, next T0. DIN holds the immediate during this cycle.
  - 010 add / 011 sub: Rout[XXX]=1, Ain=1, BusSel=XXX, next T2.
  - 100-111: Done=1, Illegal=1, no enables, next T0.
- T2 (add/sub): Rout[YYY]=1, Gin=1, BusSel=YYY, AddSub=(III==011), next T3.
- T3 (add/sub): Gout=1, Rin[XXX]=1, BusSel=8, Done=1, next T0.
- Cycle counts, edge of Run to Done:
  - mv / mvi / illegal: Done in cycle 2 (T1).
  - add / sub: Done in cycle 4 (T3).
- Back-to-back: after Done, the state is T0. A new Run is accepted on the next edge, giving zero dead cycles beyond T0.
- Run while Busy=1 is ignored; no queuing.
- IR is stable from T1 through the end of the instruction. Changes on DIN outside T0 (and outside T1 of mvi) have no effect.
- XXX==YYY is legal. For mv this gives Rout and Rin on the same register. For add, R doubles.
- InstrCount increments by 1 on each edge where Done=1, including illegal opcodes, and wraps from 2^CNT_W-1 to 0.
- Invariants:
  - Rout and Rin are each one-hot or zero.
  - At most one bus driver (Rout bit, Gout, DINout) is active per cycle, and it matches BusSel.

Test Plan:
- Reset, then idle with Run=0 for 5 cycles -> Tstep=00, Busy=0, all enables 0, BusSel=15, InstrCount=0.
- Run=1 with DIN=9'b001_011_000 (mvi R3), then DIN=9'h05 in T1 -> T1 shows DINout=1, Rin=8'b0000_1000, BusSel=9, Done=1; InstrCount=1.
- sub R1,R2 (DIN=9'b011_001_010) -> exact sequence:
  - T1: Rout=8'h02, Ain=1.
  - T2: Rout=8'h04, Gin=1, AddSub=1.
  - T3: Gout=1, Rin=8'h02, BusSel=8, Done=1.
  - Busy=1 for 3 cycles.
- Back-to-back mv R0,R7 then add R4,R4 with Run held high:
  - Cycles T0,T1,T0,T1,T2,T3 with no idle gap.
  - Done pulses in cycles 2 and 6.
  - Run pulses during Busy are ignored.
- Opcode 9'b111_000_000 -> T1: Done=1, Illegal=1, no enables; next cycle T0; InstrCount increments.
- Reset asserted in T2 of add -> next edge Tstep=00, no Done; IR=0; counter at 2^16-1 plus one Done -> InstrCount=0 (wrap, checked with a preloaded run of 65535 mv instructions or CNT_W=4 and 15 instructions).
